// File: rtl/load_hazard_tracker_pkg.sv
// Shared types for the load-use hazard tracker: register index type,
// tracked-load slot record and the slot hit test.
package load_hazard_tracker_pkg;

  // Register index width of the rv32i register file.
  localparam int unsigned RV32I_REG_W = 5;

  typedef logic [RV32I_REG_W-1:0] rv32i_reg;

  // x0 is hardwired to zero, so loads targeting it never create a hazard.
  localparam rv32i_reg HAZ_REG_ZERO = 5'd0;

  // One tracked load in a pipeline stage.
  // done marks that the load data has returned and can be forwarded.
  // The EX slot never sets done.
  typedef struct packed {
    logic     v;
    rv32i_reg rd;
    logic     done;
  } load_slot_t;

  localparam load_slot_t LOAD_SLOT_EMPTY = '{v: 1'b0, rd: 5'd0, done: 1'b0};

  // A source register depends on a slot when the slot holds a load
  // whose data is not yet available and whose rd matches a non-zero source.
  function automatic logic slot_hit(input load_slot_t slot, input rv32i_reg src);
    slot_hit = slot.v & ~slot.done & (slot.rd == src) & (src != HAZ_REG_ZERO);
  endfunction

endpackage : load_hazard_tracker_pkg

// File: rtl/load_hazard_tracker_sat_counter.sv
// Saturating up-counter. It increments by one per clock while inc is high
// and sticks at all-ones. It is reusable for any performance event.
module sat_counter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] CNT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};

  logic [WIDTH-1:0] cnt_d;
  logic [WIDTH-1:0] cnt_q;

  // Next count: step on inc unless already saturated.
  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_ONE;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= {WIDTH{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign count = cnt_q;

endmodule : sat_counter

// File: rtl/load_hazard_tracker.sv
// Load-use hazard tracker. It follows loads through EX and MEM and stalls ID
// whenever an ID source register needs load data that cannot be forwarded yet.
// When this block does not stall, whatever the forwarding mux picks from
// MEM/WB is valid.
module load_hazard_tracker
  import load_hazard_tracker_pkg::*;
#(
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_use_rs1,
  input  logic                  id_use_rs2,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_is_load,
  input  logic                  id_advance,
  input  logic                  ex_advance,
  input  logic                  mem_advance,
  input  logic                  dmem_resp,
  input  logic                  flush,
  output logic                  stall_id,
  output logic                  ex_load_pending,
  output logic                  mem_load_pending,
  output logic [CNT_W-1:0]      stall_cycles
);

  load_slot_t ex_d;
  load_slot_t ex_q;
  load_slot_t mem_d;
  load_slot_t mem_q;

  rv32i_reg rs1_c;
  rv32i_reg rs2_c;
  rv32i_reg rd_c;
  logic     hit_rs1_c;
  logic     hit_rs2_c;
  logic     stall_c;

  assign rs1_c = rv32i_reg'(id_rs1);
  assign rs2_c = rv32i_reg'(id_rs2);
  assign rd_c  = rv32i_reg'(id_rd);

  // Stall decision. It is combinational so that ID holds in the same cycle
  // that the dependency becomes visible. Flush always wins because the ID
  // instruction is being squashed anyway.
  always_comb begin
    hit_rs1_c = slot_hit(ex_q, rs1_c) | slot_hit(mem_q, rs1_c);
    hit_rs2_c = slot_hit(ex_q, rs2_c) | slot_hit(mem_q, rs2_c);
    stall_c   = 1'b0;
    if (flush) begin
      stall_c = 1'b0;
    end else begin
      stall_c = (id_use_rs1 & hit_rs1_c) | (id_use_rs2 & hit_rs2_c);
    end
  end

  // MEM slot next state. An ex_advance always overwrites the slot, because
  // the pipeline only advances EX when MEM is vacating. A dmem_resp that
  // coincides with ex_advance belongs to the departing load, which WB
  // forwarding covers, so the incoming entry starts with done clear.
  always_comb begin
    mem_d = mem_q;
    if (ex_advance) begin
      mem_d = '{v: ex_q.v, rd: ex_q.rd, done: 1'b0};
    end else if (mem_advance) begin
      mem_d = LOAD_SLOT_EMPTY;
    end else if (dmem_resp && mem_q.v) begin
      mem_d.done = 1'b1;
    end else begin
      mem_d = mem_q;
    end
  end

  // EX slot next state. Flush squashes the slot. A new instruction enters
  // only when ID really advances. Otherwise a departing EX leaves a bubble.
  // Loads to x0 are dropped here, even if the decoder flags them.
  always_comb begin
    ex_d = ex_q;
    if (flush) begin
      ex_d = LOAD_SLOT_EMPTY;
    end else if (id_advance && !stall_c) begin
      ex_d = '{v: id_is_load & (rd_c != HAZ_REG_ZERO), rd: rd_c, done: 1'b0};
    end else if (ex_advance) begin
      ex_d.v = 1'b0;
    end else begin
      ex_d = ex_q;
    end
  end

  // Slot registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q  <= LOAD_SLOT_EMPTY;
      mem_q <= LOAD_SLOT_EMPTY;
    end else begin
      ex_q  <= ex_d;
      mem_q <= mem_d;
    end
  end

  // Count every cycle spent stalling ID.
  sat_counter #(
    .WIDTH (CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (stall_c),
    .count (stall_cycles)
  );

  assign stall_id         = stall_c;
  assign ex_load_pending  = ex_q.v;
  assign mem_load_pending = mem_q.v & ~mem_q.done;

endmodule : load_hazard_tracker

// File: tb/tb_load_hazard_tracker.sv
// Directed testbench for load_hazard_tracker. The counter width is narrowed
// to 4 bits so that saturation is reachable in a few cycles.
module tb_load_hazard_tracker;

  localparam int CNT_W = 4;

  logic             clk;
  logic             rst_n;
  logic [4:0]       id_rs1;
  logic [4:0]       id_rs2;
  logic             id_use_rs1;
  logic             id_use_rs2;
  logic [4:0]       id_rd;
  logic             id_is_load;
  logic             id_advance;
  logic             ex_advance;
  logic             mem_advance;
  logic             dmem_resp;
  logic             flush;
  logic             stall_id;
  logic             ex_load_pending;
  logic             mem_load_pending;
  logic [CNT_W-1:0] stall_cycles;

  int errors = 0;
  int checks = 0;

  load_hazard_tracker #(
    .REG_ADDR_W (5),
    .CNT_W      (CNT_W)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .id_rs1           (id_rs1),
    .id_rs2           (id_rs2),
    .id_use_rs1       (id_use_rs1),
    .id_use_rs2       (id_use_rs2),
    .id_rd            (id_rd),
    .id_is_load       (id_is_load),
    .id_advance       (id_advance),
    .ex_advance       (ex_advance),
    .mem_advance      (mem_advance),
    .dmem_resp        (dmem_resp),
    .flush            (flush),
    .stall_id         (stall_id),
    .ex_load_pending  (ex_load_pending),
    .mem_load_pending (mem_load_pending),
    .stall_cycles     (stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle();
    id_rs1 = 5'd0; id_rs2 = 5'd0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
    id_rd = 5'd0; id_is_load = 1'b0; id_advance = 1'b0;
    ex_advance = 1'b0; mem_advance = 1'b0; dmem_resp = 1'b0; flush = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  // Put a load to rd into ID and let it advance into EX.
  task automatic issue_load(input logic [4:0] rd);
    idle();
    id_rd = rd; id_is_load = 1'b1; id_advance = 1'b1;
    tick();
  endtask

  // Put a non-load consumer into ID, which tries to advance.
  task automatic set_consumer(input logic [4:0] rs1, input logic u1,
                              input logic [4:0] rs2, input logic u2,
                              input logic [4:0] rd);
    idle();
    id_rs1 = rs1; id_use_rs1 = u1; id_rs2 = rs2; id_use_rs2 = u2;
    id_rd = rd; id_advance = 1'b1;
  endtask

  task automatic test_reset();
    idle();
    rst_n = 1'b0;
    #12;
    if (stall_id !== 1'b0) begin $display("FAIL rst_stall: got %0b want 0", stall_id); errors++; end
    checks++;
    if (stall_cycles !== 4'd0) begin $display("FAIL rst_cnt: got %0d want 0", stall_cycles); errors++; end
    checks++;
    if ({ex_load_pending, mem_load_pending} !== 2'b00) begin
      $display("FAIL rst_pending: got %b want 00", {ex_load_pending, mem_load_pending}); errors++;
    end
    checks++;
    tick();
    rst_n = 1'b1;
  endtask

  // ADD x6,x5,x1 right behind LW x5: EX hit, then MEM hit resolved by dmem_resp.
  task automatic test_load_use();
    do_reset();
    issue_load(5'd5);
    set_consumer(5'd5, 1'b1, 5'd1, 1'b1, 5'd6);
    ex_advance = 1'b1;
    @(negedge clk);
    if (stall_id !== 1'b1) begin $display("FAIL lu_ex_stall: got %0b want 1", stall_id); errors++; end
    checks++;
    if (ex_load_pending !== 1'b1) begin $display("FAIL lu_ex_pend: got %0b want 1", ex_load_pending); errors++; end
    checks++;
    tick();
    ex_advance = 1'b0; dmem_resp = 1'b1;
    @(negedge clk);
    if (stall_id !== 1'b1) begin $display("FAIL lu_mem_stall: got %0b want 1", stall_id); errors++; end
    checks++;
    if ({ex_load_pending, mem_load_pending} !== 2'b01) begin
      $display("FAIL lu_mem_pend: got %b want 01", {ex_load_pending, mem_load_pending}); errors++;
    end
    checks++;
    tick();
    dmem_resp = 1'b0;
    @(negedge clk);
    if (stall_id !== 1'b0) begin $display("FAIL lu_done_stall: got %0b want 0", stall_id); errors++; end
    checks++;
    if (mem_load_pending !== 1'b0) begin $display("FAIL lu_done_pend: got %0b want 0", mem_load_pending); errors++; end
    checks++;
    if (stall_cycles !== 4'd2) begin $display("FAIL lu_cnt: got %0d want 2", stall_cycles); errors++; end
    checks++;
    tick();
    idle();
  endtask

  // Consumer on rs2, dmem_resp arrives in the third MEM cycle: 4 stall cycles.
  task automatic test_delayed_resp();
    do_reset();
    issue_load(5'd5);
    set_consumer(5'd3, 1'b1, 5'd5, 1'b1, 5'd8);
    ex_advance = 1'b1;
    @(negedge clk);
    if (stall_id !== 1'b1) begin $display("FAIL dr_stall_c0: got %0b want 1", stall_id); errors++; end
    checks++;
    tick();
    ex_advance = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      dmem_resp = (k == 3) ? 1'b1 : 1'b0;
      @(negedge clk);
      if (stall_id !== 1'b1) begin $display("FAIL dr_stall_c%0d: got %0b want 1", k, stall_id); errors++; end
      checks++;
      tick();
    end
    dmem_resp = 1'b0;
    @(negedge clk);
    if (stall_id !== 1'b0) begin $display("FAIL dr_release: got %0b want 0", stall_id); errors++; end
    checks++;
    if (stall_cycles !== 4'd4) begin $display("FAIL dr_cnt: got %0d want 4", stall_cycles); errors++; end
    checks++;
    tick();
    idle();
  endtask

  // Load leaves MEM via mem_advance without a dmem_resp: stall drops.
  task automatic test_mem_leave();
    do_reset();
    issue_load(5'd9);
    set_consumer(5'd9, 1'b1, 5'd0, 1'b0, 5'd10);
    ex_advance = 1'b1;
    @(negedge clk);
    if (stall_id !== 1'b1) begin $display("FAIL ml_ex_stall: got %0b want 1", stall_id); errors++; end
    checks++;
    tick();
    ex_advance = 1'b0; mem_advance = 1'b1;
    @(negedge clk);
    if (stall_id !== 1'b1) begin $display("FAIL ml_mem_stall: got %0b want 1", stall_id); errors++; end
    checks++;
    tick();
    mem_advance = 1'b0;
    @(negedge clk);
    if (stall_id !== 1'b0) begin $display("FAIL ml_release: got %0b want 0", stall_id); errors++; end
    checks++;
    if ({ex_load_pending, mem_load_pending} !== 2'b00) begin
      $display("FAIL ml_pend: got %b want 00", {ex_load_pending, mem_load_pending}); errors++;
    end
    checks++;
    tick();
    idle();
  endtask

  // A load to x0 is never tracked, and readers of x0 never stall.
  task automatic test_x0();
    do_reset();
    issue_load(5'd0);
    set_consumer(5'd0, 1'b1, 5'd0, 1'b1, 5'd4);
    @(negedge clk);
    if (ex_load_pending !== 1'b0) begin $display("FAIL x0_pend: got %0b want 0", ex_load_pending); errors++; end
    checks++;
    if (stall_id !== 1'b0) begin $display("FAIL x0_stall: got %0b want 0", stall_id); errors++; end
    checks++;
    tick();
    idle();
  endtask

  // Flush with a dependent consumer in ID: no stall, and the EX slot is squashed.
  task automatic test_flush();
    do_reset();
    issue_load(5'd7);
    set_consumer(5'd7, 1'b1, 5'd0, 1'b0, 5'd2);
    flush = 1'b1;
    @(negedge clk);
    if (stall_id !== 1'b0) begin $display("FAIL fl_stall: got %0b want 0", stall_id); errors++; end
    checks++;
    if (ex_load_pending !== 1'b1) begin $display("FAIL fl_pre_pend: got %0b want 1", ex_load_pending); errors++; end
    checks++;
    tick();
    set_consumer(5'd0, 1'b0, 5'd7, 1'b1, 5'd3);
    @(negedge clk);
    if (ex_load_pending !== 1'b0) begin $display("FAIL fl_post_pend: got %0b want 0", ex_load_pending); errors++; end
    checks++;
    if (stall_id !== 1'b0) begin $display("FAIL fl_later_stall: got %0b want 0", stall_id); errors++; end
    checks++;
    tick();
    idle();
  endtask

  // Two loads back to back. dmem_resp together with ex_advance belongs to the
  // departing load, so the incoming load still blocks its consumer.
  task automatic test_back_to_back();
    do_reset();
    issue_load(5'd5);
    id_rd = 5'd6; id_is_load = 1'b1; id_advance = 1'b1; ex_advance = 1'b1;
    @(negedge clk);
    if (stall_id !== 1'b0) begin $display("FAIL bb_no_stall: got %0b want 0", stall_id); errors++; end
    checks++;
    tick();
    set_consumer(5'd5, 1'b1, 5'd6, 1'b1, 5'd11);
    ex_advance = 1'b1; dmem_resp = 1'b1;
    @(negedge clk);
    if (stall_id !== 1'b1) begin $display("FAIL bb_stall_c0: got %0b want 1", stall_id); errors++; end
    checks++;
    if ({ex_load_pending, mem_load_pending} !== 2'b11) begin
      $display("FAIL bb_pend_c0: got %b want 11", {ex_load_pending, mem_load_pending}); errors++;
    end
    checks++;
    tick();
    ex_advance = 1'b0; dmem_resp = 1'b1;
    @(negedge clk);
    if (stall_id !== 1'b1) begin $display("FAIL bb_stall_c1: got %0b want 1", stall_id); errors++; end
    checks++;
    if ({ex_load_pending, mem_load_pending} !== 2'b01) begin
      $display("FAIL bb_pend_c1: got %b want 01", {ex_load_pending, mem_load_pending}); errors++;
    end
    checks++;
    tick();
    dmem_resp = 1'b0;
    @(negedge clk);
    if (stall_id !== 1'b0) begin $display("FAIL bb_release: got %0b want 0", stall_id); errors++; end
    checks++;
    tick();
    idle();
  endtask

  // rst_n dropped mid-stall clears outputs before any clock edge.
  task automatic test_async_reset();
    do_reset();
    issue_load(5'd5);
    set_consumer(5'd5, 1'b1, 5'd0, 1'b0, 5'd6);
    tick(); tick(); tick();
    @(negedge clk);
    if (stall_cycles !== 4'd3) begin $display("FAIL ar_pre_cnt: got %0d want 3", stall_cycles); errors++; end
    checks++;
    #2;
    rst_n = 1'b0;
    #1;
    if (stall_id !== 1'b0) begin $display("FAIL ar_stall: got %0b want 0", stall_id); errors++; end
    checks++;
    if (stall_cycles !== 4'd0) begin $display("FAIL ar_cnt: got %0d want 0", stall_cycles); errors++; end
    checks++;
    if (ex_load_pending !== 1'b0) begin $display("FAIL ar_pend: got %0b want 0", ex_load_pending); errors++; end
    checks++;
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    if (stall_id !== 1'b0) begin $display("FAIL ar_post_stall: got %0b want 0", stall_id); errors++; end
    checks++;
    tick();
    idle();
  endtask

  // Hold a stall until the 4-bit counter reaches 14, then 5 more cycles: stays 15.
  task automatic test_saturate();
    logic [CNT_W-1:0] exp_cnt;
    do_reset();
    issue_load(5'd12);
    set_consumer(5'd12, 1'b1, 5'd0, 1'b0, 5'd13);
    for (int i = 0; i <= 18; i++) begin
      @(negedge clk);
      exp_cnt = (i >= 15) ? 4'd15 : 4'(i);
      if (stall_id !== 1'b1) begin $display("FAIL sat_stall_%0d: got %0b want 1", i, stall_id); errors++; end
      checks++;
      if (i >= 13) begin
        if (stall_cycles !== exp_cnt) begin
          $display("FAIL sat_cnt_%0d: got %0d want %0d", i, stall_cycles, exp_cnt); errors++;
        end
        checks++;
      end
      tick();
    end
    idle();
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    test_reset();
    test_load_use();
    test_delayed_resp();
    test_mem_leave();
    test_x0();
    test_flush();
    test_back_to_back();
    test_async_reset();
    test_saturate();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_load_hazard_tracker

// File: doc/load_hazard_tracker.md
Name: load_hazard_tracker

Overview:
- Producer-side companion to EX-stage operand forwarding.
- Tracks loads in flight in EX and MEM whose data cannot yet be forwarded to a consumer.
- Raises a stall to the ID stage when an ID instruction's source register depends on such a load.
- Sits beside the pipeline control; the forwarding mux stays purely combinational, and this block guarantees that anything it selects from MEM/WB is valid.

Parameters:
- REG_ADDR_W, 5, register index width (rv32i_reg).
- CNT_W, 32, width of saturating stall performance counter.

Ports:
- clk  in  1  pipeline clock.
- rst_n  in  1  asynchronous active-low reset.
- id_rs1  in  REG_ADDR_W  ID source 1.
- id_rs2  in  REG_ADDR_W  ID source 2.
- id_use_rs1  in  1  ID instruction reads rs1.
- id_use_rs2  in  1  ID instruction reads rs2.
- id_rd  in  REG_ADDR_W  ID destination.
- id_is_load  in  1  ID instruction is a load with rd != 0.
- id_advance  in  1  ID→EX register loads this cycle.
- ex_advance  in  1  EX→MEM register loads this cycle.
- mem_advance  in  1  MEM→WB register loads this cycle.
- dmem_resp  in  1  data memory response for the load in MEM.
- flush  in  1  squash ID and EX (branch mispredict).
- stall_id  out  1  hold PC and IF/ID, inject bubble into EX.
- ex_load_pending  out  1  debug: EX slot valid.
- mem_load_pending  out  1  debug: MEM slot valid and not done.
- stall_cycles  out  CNT_W  saturating count of cycles with stall_id=1.

Behaviour:
- Reset is asynchronous on rst_n low. It clears both slots, clears stall_cycles, and forces stall_id=0.
- Two tracked slots:
  - EX slot: {v, rd}.
  - MEM slot: {v, rd, done}.
- Slot update each rising clk edge, priority order top-down:
  - flush=1: EX slot cleared. The MEM slot updates normally, because the MEM instruction is older than the branch.
  - ex_advance=1: MEM slot ← {EX.v, EX.rd, done=0}. The MEM slot is overwritten even if the old MEM slot did not retire via mem_advance; the pipeline guarantees ex_advance implies MEM is vacating.
  - Otherwise, mem_advance=1: MEM slot cleared.
  - dmem_resp=1 with MEM.v and no ex_advance: MEM.done ← 1.
  - dmem_resp coinciding with ex_advance applies to the departing load. That load goes to WB, and WB forwarding covers it.
  - id_advance=1 and not stall_id and not flush: EX slot ← {id_is_load, id_rd}.
  - Otherwise, if ex_advance: EX.v ← 0 (bubble).
- Loads with rd=0 are never tracked. The block itself masks id_rd==0 even if id_is_load=1.
- Hit definitions:
  - hit_ex = EX.v and EX.rd==src and src!=0.
  - hit_mem = MEM.v and !MEM.done and MEM.rd==src and src!=0.
- stall_id is combinational, zero latency: it equals (use_rs1 and (hit_ex or hit_mem for rs1)) or (same for rs2). It is never asserted during flush.
- Load-use timing:
  - A dependent instruction immediately behind a load stalls at least 1 cycle.
  - It stalls additional cycles until dmem_resp, or until the load leaves MEM.
- Once MEM.done=1, no stall occurs. The forwarding unit selects the MEM value and the datapath muxes load data.
- stall_cycles increments by 1 per clk with stall_id=1 and saturates at all-ones.
- Reset mid-stall: stall_id drops asynchronously with rst_n low.

Decomposition:
- rv32i_types supplies rv32i_reg.
- Add to the shared package:
  - load_slot_t struct {v, rd, done}.
  - HAZ_REG_ZERO constant.
- Natural sub-module: sat_counter (parameterised width, inc, async active-low reset), reusable for other perf counters.
- Slot logic stays inline.

Test Plan:
- Reset with stall_cycles nonzero, rst_n=0 mid-cycle -> outputs 0 immediately, before the next clk.
- Load x5 issues, then ADD x6,x5,x1 in ID -> stall_id=1 for 1 cycle (EX hit). With the load in MEM and dmem_resp in the same cycle -> stall drops the next cycle.
- Load x5 in MEM, dmem_resp delayed 3 cycles, consumer rs2=x5 -> stall_id=1 for 4 cycles total; stall_cycles=4.
- Load x0, consumer reads x0 -> stall_id never asserts.
- Load x7 in EX, flush=1 with consumer in ID -> no stall that cycle; EX slot empty after the edge; a later reader of x7 does not stall.
- Force stall_cycles to 2^CNT_W−2, hold stall for 5 cycles -> counter holds at all-ones.
